// File: rtl/mem_stage.sv
// ==== mem_stage: MEM pipeline stage with memory handshake, timeout abort, halt and MEM/WB regs ====
// Rev 1.0
`default_nettype none

module mem_stage #(
  parameter int TIMEOUT   = 15,
  parameter int ALIGN_CHK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALU_Out,
  input  logic [15:0] WrData,
  input  logic        MemRead,
  input  logic        MemWrt,
  input  logic        Valid,
  input  logic        nHaltSig,
  input  logic        RegWrt,
  input  logic [2:0]  WrReg,
  input  logic        WbSel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        Stall,
  output logic [15:0] WB_Data,
  output logic [2:0]  WB_Reg,
  output logic        WB_RegWrt,
  output logic        Halt_wb,
  output logic        Err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t      state;
  logic [3:0]  wait_cnt;

  logic        live;
  logic        misalign;
  logic        access;
  logic        bad_op;
  logic        halt_now;
  logic        timeout;
  logic        req_int;
  logic        err_now;
  logic        load_done;
  logic [15:0] wb_data_next;
  logic        wb_we_next;

  assign live     = Valid & nHaltSig;
  assign misalign = (ALIGN_CHK != 0) & ALU_Out[0] & (MemRead | MemWrt);
  assign access   = live & (MemRead ^ MemWrt) & ~misalign;
  assign bad_op   = live & ((MemRead & MemWrt) | misalign);
  assign halt_now = Valid & ~nHaltSig;
  assign timeout  = (state == WAIT) & ~mem_ready & (wait_cnt == TIMEOUT_CNT);

  always_comb begin
    req_int = 1'b0;
    err_now = 1'b0;
    case (state)
      IDLE: begin
        req_int = access;
        err_now = bad_op;
      end
      WAIT: begin
        req_int = ~timeout;
        err_now = timeout;
      end
      default: begin
        req_int = 1'b0;
        err_now = 1'b0;
      end
    endcase
  end

  // Gating with rst keeps the request low while reset is held, even though IDLE is combinational.
  assign mem_req   = rst & req_int;
  assign mem_we    = mem_req & MemWrt;
  assign mem_addr  = mem_req ? ALU_Out : 16'h0000;
  assign mem_wdata = mem_req ? WrData  : 16'h0000;
  assign Stall     = mem_req & ~mem_ready;

  assign load_done    = mem_req & mem_ready & MemRead;
  assign wb_data_next = (WbSel & load_done) ? mem_rdata : ALU_Out;
  assign wb_we_next   = RegWrt & Valid & ~err_now & (state != HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      WB_Data   <= 16'h0000;
      WB_Reg    <= 3'd0;
      WB_RegWrt <= 1'b0;
      Halt_wb   <= 1'b0;
      Err       <= 1'b0;
    end else begin
      if (err_now) Err <= 1'b1;

      if (!Stall) begin
        WB_Data   <= wb_data_next;
        WB_Reg    <= WrReg;
        WB_RegWrt <= wb_we_next;
      end

      case (state)
        IDLE: begin
          if (halt_now) begin
            state   <= HALTED;
            Halt_wb <= 1'b1;
          end else if (access && !mem_ready) begin
            state    <= WAIT;
            wait_cnt <= 4'd0;
          end
        end
        WAIT: begin
          if (mem_ready || timeout) state <= IDLE;
          else                      wait_cnt <= wait_cnt + 4'd1;
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ==== tb_mem_stage: table vectors plus multi-cycle sequences for mem_stage ====
// Rev 1.0
`default_nettype none

module tb_mem_stage;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ALU_Out, WrData, mem_rdata;
  logic        MemRead, MemWrt, Valid, nHaltSig, RegWrt, WbSel, mem_ready;
  logic [2:0]  WrReg;
  logic        mem_req, mem_we, Stall, WB_RegWrt, Halt_wb, Err;
  logic [15:0] mem_addr, mem_wdata, WB_Data;
  logic [2:0]  WB_Reg;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT(TO), .ALIGN_CHK(1)) dut (
    .clk(clk), .rst(rst), .ALU_Out(ALU_Out), .WrData(WrData),
    .MemRead(MemRead), .MemWrt(MemWrt), .Valid(Valid), .nHaltSig(nHaltSig),
    .RegWrt(RegWrt), .WrReg(WrReg), .WbSel(WbSel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .Stall(Stall),
    .WB_Data(WB_Data), .WB_Reg(WB_Reg), .WB_RegWrt(WB_RegWrt),
    .Halt_wb(Halt_wb), .Err(Err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] alu, wd, rdt;
    logic        rd, wr, vld, nh, rw;
    logic [2:0]  rg;
    logic        ws, rdy;
    logic        e_req, e_we;
    logic [15:0] e_addr, e_wdata, e_wbd;
    logic [2:0]  e_wbr;
    logic        e_wbw, e_err;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  rg;
    logic        rw;
  } wb_t;

  vec_t tbl [8];
  wb_t  sbq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [15:0] alu, wd, rdt, input logic rd, wr, vld, nh, rw,
                       input logic [2:0] rg, input logic ws, rdy);
    ALU_Out = alu; WrData = wd; mem_rdata = rdt; MemRead = rd; MemWrt = wr;
    Valid = vld; nHaltSig = nh; RegWrt = rw; WrReg = rg; WbSel = ws; mem_ready = rdy;
  endtask

  task automatic idle_in();
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pop_chk(input string nm);
    wb_t e;
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_wbdata"}, {16'h0, WB_Data}, {16'h0, e.data});
      chk({nm, "_wbreg"}, {29'h0, WB_Reg}, {29'h0, e.rg});
      chk({nm, "_wbwrt"}, {31'h0, WB_RegWrt}, {31'h0, e.rw});
    end
  endtask

  int stalls;
  bit aborted;

  initial begin
    // vectors: single-cycle accesses with an immediate ready, plus error and non-memory cases
    tbl[0] = '{alu:16'h0010, wd:16'hAAAA, rdt:16'hBEEF, rd:1, wr:0, vld:1, nh:1, rw:1, rg:3, ws:1, rdy:1,
               e_req:1, e_we:0, e_addr:16'h0010, e_wdata:16'hAAAA, e_wbd:16'hBEEF, e_wbr:3, e_wbw:1, e_err:0};
    tbl[1] = '{alu:16'h0040, wd:16'h5555, rdt:16'h0000, rd:0, wr:1, vld:1, nh:1, rw:0, rg:1, ws:0, rdy:1,
               e_req:1, e_we:1, e_addr:16'h0040, e_wdata:16'h5555, e_wbd:16'h0040, e_wbr:1, e_wbw:0, e_err:0};
    tbl[2] = '{alu:16'h7777, wd:16'h9999, rdt:16'h0000, rd:0, wr:0, vld:1, nh:1, rw:1, rg:5, ws:0, rdy:1,
               e_req:0, e_we:0, e_addr:16'h0000, e_wdata:16'h0000, e_wbd:16'h7777, e_wbr:5, e_wbw:1, e_err:0};
    tbl[3] = '{alu:16'h0100, wd:16'h0000, rdt:16'h1234, rd:1, wr:0, vld:0, nh:1, rw:1, rg:2, ws:1, rdy:1,
               e_req:0, e_we:0, e_addr:16'h0000, e_wdata:16'h0000, e_wbd:16'h0100, e_wbr:2, e_wbw:0, e_err:0};
    tbl[4] = '{alu:16'h0011, wd:16'h0000, rdt:16'h2222, rd:1, wr:0, vld:1, nh:1, rw:1, rg:4, ws:1, rdy:1,
               e_req:0, e_we:0, e_addr:16'h0000, e_wdata:16'h0000, e_wbd:16'h0011, e_wbr:4, e_wbw:0, e_err:1};
    tbl[5] = '{alu:16'h0030, wd:16'h3333, rdt:16'h0000, rd:1, wr:1, vld:1, nh:1, rw:1, rg:6, ws:1, rdy:1,
               e_req:0, e_we:0, e_addr:16'h0000, e_wdata:16'h0000, e_wbd:16'h0030, e_wbr:6, e_wbw:0, e_err:1};
    tbl[6] = '{alu:16'h0050, wd:16'h0000, rdt:16'h1111, rd:1, wr:0, vld:1, nh:1, rw:1, rg:7, ws:0, rdy:1,
               e_req:1, e_we:0, e_addr:16'h0050, e_wdata:16'h0000, e_wbd:16'h0050, e_wbr:7, e_wbw:1, e_err:0};
    tbl[7] = '{alu:16'h0033, wd:16'h4444, rdt:16'h0000, rd:0, wr:1, vld:1, nh:1, rw:0, rg:0, ws:0, rdy:1,
               e_req:0, e_we:0, e_addr:16'h0000, e_wdata:16'h0000, e_wbd:16'h0033, e_wbr:0, e_wbw:0, e_err:1};

    rst = 1'b0;
    idle_in();
    #2;
    chk("rst_req", {31'h0, mem_req}, 32'd0);
    chk("rst_stall", {31'h0, Stall}, 32'd0);
    chk("rst_wbdata", {16'h0, WB_Data}, 32'd0);
    chk("rst_wbreg", {29'h0, WB_Reg}, 32'd0);
    chk("rst_wbwrt", {31'h0, WB_RegWrt}, 32'd0);
    chk("rst_halt", {31'h0, Halt_wb}, 32'd0);
    chk("rst_err", {31'h0, Err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_reset();
      drive(tbl[i].alu, tbl[i].wd, tbl[i].rdt, tbl[i].rd, tbl[i].wr, tbl[i].vld, tbl[i].nh,
            tbl[i].rw, tbl[i].rg, tbl[i].ws, tbl[i].rdy);
      sbq.push_back('{data:tbl[i].e_wbd, rg:tbl[i].e_wbr, rw:tbl[i].e_wbw});
      #1;
      chk($sformatf("v%0d_req", i), {31'h0, mem_req}, {31'h0, tbl[i].e_req});
      chk($sformatf("v%0d_we", i), {31'h0, mem_we}, {31'h0, tbl[i].e_we});
      chk($sformatf("v%0d_addr", i), {16'h0, mem_addr}, {16'h0, tbl[i].e_addr});
      chk($sformatf("v%0d_wdata", i), {16'h0, mem_wdata}, {16'h0, tbl[i].e_wdata});
      chk($sformatf("v%0d_stall", i), {31'h0, Stall}, 32'd0);
      @(posedge clk);
      #1;
      pop_chk($sformatf("v%0d", i));
      chk($sformatf("v%0d_err", i), {31'h0, Err}, {31'h0, tbl[i].e_err});
    end

    // store held off by three not-ready cycles; MEM/WB must hold meanwhile
    do_reset();
    drive(16'h4242, 16'h0, 16'h0, 0, 0, 1, 1, 1, 3'd6, 0, 1);
    @(posedge clk); #1;
    chk("st_pre_wbdata", {16'h0, WB_Data}, 32'h4242);
    @(negedge clk);
    drive(16'h0020, 16'h1234, 16'h0, 0, 1, 1, 1, 0, 3'd1, 0, 0);
    stalls = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("st_c%0d_req", c), {31'h0, mem_req}, 32'd1);
      chk($sformatf("st_c%0d_we", c), {31'h0, mem_we}, 32'd1);
      chk($sformatf("st_c%0d_addr", c), {16'h0, mem_addr}, 32'h0020);
      chk($sformatf("st_c%0d_wdata", c), {16'h0, mem_wdata}, 32'h1234);
      if (Stall) stalls++;
      @(posedge clk); #1;
      chk($sformatf("st_c%0d_hold", c), {16'h0, WB_Data}, 32'h4242);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    chk("st_done_req", {31'h0, mem_req}, 32'd1);
    chk("st_done_stall", {31'h0, Stall}, 32'd0);
    chk("st_stall_cycles", stalls, 32'd3);
    sbq.push_back('{data:16'h0020, rg:3'd1, rw:1'b0});
    @(posedge clk); #1;
    pop_chk("st_done");
    chk("st_err", {31'h0, Err}, 32'd0);

    // load that never completes aborts after the wait budget
    do_reset();
    drive(16'h0060, 16'h0, 16'hDEAD, 1, 0, 1, 1, 1, 3'd2, 1, 0);
    stalls = 0;
    aborted = 1'b0;
    for (int c = 0; c < 40 && !aborted; c++) begin
      #1;
      if (Stall) begin
        stalls++;
        @(posedge clk);
        @(negedge clk);
      end else begin
        aborted = 1'b1;
        chk("to_abort_req", {31'h0, mem_req}, 32'd0);
        chk("to_err_before_edge", {31'h0, Err}, 32'd0);
      end
    end
    chk("to_seen", {31'h0, aborted}, 32'd1);
    chk("to_stall_cycles", stalls, TO + 1);
    @(posedge clk); #1;
    chk("to_err", {31'h0, Err}, 32'd1);
    chk("to_wbwrt", {31'h0, WB_RegWrt}, 32'd0);
    chk("to_wbdata", {16'h0, WB_Data}, 32'h0060);
    Valid = 1'b0;
    #1;
    chk("to_after_stall", {31'h0, Stall}, 32'd0);

    // halt, then a later load must be ignored
    do_reset();
    drive(16'h0, 16'h0, 16'h0, 0, 0, 1, 0, 0, 3'd0, 0, 1);
    #1;
    chk("h_req", {31'h0, mem_req}, 32'd0);
    @(posedge clk); #1;
    chk("h_halt", {31'h0, Halt_wb}, 32'd1);
    @(negedge clk);
    drive(16'h0010, 16'h0, 16'h5A5A, 1, 0, 1, 1, 1, 3'd4, 1, 1);
    #1;
    chk("h_load_req", {31'h0, mem_req}, 32'd0);
    chk("h_load_stall", {31'h0, Stall}, 32'd0);
    @(posedge clk); #1;
    chk("h_load_wbwrt", {31'h0, WB_RegWrt}, 32'd0);
    chk("h_halt_held", {31'h0, Halt_wb}, 32'd1);
    chk("h_err", {31'h0, Err}, 32'd0);

    // reset asserted in the middle of a wait, then normal operation resumes
    do_reset();
    drive(16'h0011, 16'h0, 16'h0, 1, 0, 1, 1, 1, 3'd1, 1, 1);
    @(posedge clk); @(negedge clk);
    drive(16'h0777, 16'h0, 16'h0, 0, 0, 1, 1, 1, 3'd3, 0, 1);
    @(posedge clk); #1;
    chk("rw_pre_err", {31'h0, Err}, 32'd1);
    chk("rw_pre_wbwrt", {31'h0, WB_RegWrt}, 32'd1);
    @(negedge clk);
    drive(16'h0080, 16'h0, 16'h0, 1, 0, 1, 1, 1, 3'd5, 1, 0);
    @(posedge clk); @(negedge clk);
    #1;
    chk("rw_wait_stall", {31'h0, Stall}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rw_req", {31'h0, mem_req}, 32'd0);
    chk("rw_stall", {31'h0, Stall}, 32'd0);
    chk("rw_err", {31'h0, Err}, 32'd0);
    chk("rw_wbwrt", {31'h0, WB_RegWrt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 16'hCAFE;
    #1;
    chk("rw_resume_req", {31'h0, mem_req}, 32'd1);
    sbq.push_back('{data:16'hCAFE, rg:3'd5, rw:1'b1});
    @(posedge clk); #1;
    pop_chk("rw_resume");

    chk("sb_drained", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum wait cycles per memory access before abort.
REQ-002 Parameter ALIGN_CHK, default 1: when 1, a word access with address bit 0 set is an error.
REQ-003 Ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ALU_Out  in  16  flopped execute result; the memory address for loads/stores.
- WrData  in  16  store data.
- MemRead  in  1  load.
- MemWrt  in  1  store.
- Valid  in  1  instruction present; 0 means bubble.
- nHaltSig  in  1  0 means halt instruction.
- RegWrt  in  1  writeback enable.
- WrReg  in  3  destination register.
- WbSel  in  1  1 selects memory data, 0 selects ALU_Out.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  read data, valid when mem_ready=1.
- mem_ready  in  1  access complete.
- Stall  out  1  freezes upstream stages.
- WB_Data  out  16  registered writeback data.
- WB_Reg  out  3  registered destination.
- WB_RegWrt  out  1  registered writeback enable.
- Halt_wb  out  1  halt reached writeback.
- Err  out  1  sticky error.

Function
REQ-004 Access condition: Valid=1, nHaltSig=1, exactly one of MemRead/MemWrt set, and no misalignment.
REQ-005 States are IDLE, WAIT and HALTED; the state is held in flops.
REQ-006 In IDLE with the access condition true, the request is combinational in the same cycle:
- mem_req=1;
- mem_we=MemWrt;
- mem_addr=ALU_Out;
- mem_wdata=WrData.
REQ-007 Stall=mem_req AND NOT mem_ready in IDLE and WAIT; Stall=0 in HALTED.
REQ-008 IDLE transitions:
- access with mem_ready=1 completes in the same cycle, no stall, and the state stays IDLE;
- access with mem_ready=0 moves to WAIT.
REQ-009 WAIT behaviour:
- mem_req, mem_we, mem_addr and mem_wdata are driven from the still-stable inputs (upstream is stalled);
- a 4-bit wait counter is cleared on entry and increments each cycle mem_ready=0.
REQ-010 WAIT exit on mem_ready=1: complete the access and go to IDLE.
REQ-011 WAIT abort: when the counter reaches TIMEOUT with mem_ready=0:
- set Err;
- drop mem_req;
- go to IDLE;
- the MEM/WB entry has WB_RegWrt=0.
REQ-012 On each clock edge with Stall=0, the MEM/WB registers load:
- WB_Data = mem_rdata if WbSel=1 and a load completed, else ALU_Out;
- WB_Reg = WrReg;
- WB_RegWrt = RegWrt AND Valid AND no error this instruction.
REQ-013 When Stall=1, the MEM/WB registers hold their values.
REQ-014 A bubble (Valid=0) loads WB_RegWrt=0 and drives no memory request.
REQ-015 MemRead and MemWrt both 1 with Valid=1: set Err, issue no access, load WB_RegWrt=0.
REQ-016 Misaligned access (ALIGN_CHK=1, ALU_Out[0]=1, Valid=1, load or store): set Err, issue no access, load WB_RegWrt=0.
REQ-017 Halt: Valid=1 with nHaltSig=0 in IDLE:
- no access;
- Halt_wb=1 on the next edge;
- state moves to HALTED.
REQ-018 HALTED is terminal until reset:
- mem_req=0 and Stall=0;
- WB_RegWrt=0 for all later inputs;
- Halt_wb held at 1.
REQ-019 Err is sticky until reset and never clears otherwise.
REQ-020 Outside an active request, mem_we, mem_addr and mem_wdata are 0.

Reset
REQ-021 rst=0 forces the following immediately, independent of clk:
- state=IDLE and wait counter=0;
- mem_req=0 and Stall=0;
- WB_Data=0, WB_Reg=0, WB_RegWrt=0;
- Halt_wb=0 and Err=0.
REQ-022 Reset asserted during WAIT drops mem_req in the same cycle; no partial result is written.
REQ-023 Operation resumes on the first rising clk edge after rst returns to 1.

Verification
REQ-024 Load ALU_Out=0x0010, WbSel=1, RegWrt=1, WrReg=3, mem_ready=1, mem_rdata=0xBEEF -> Stall=0; next edge WB_Data=0xBEEF, WB_Reg=3, WB_RegWrt=1.
REQ-025 Store ALU_Out=0x0020, WrData=0x1234, mem_ready low for 3 cycles -> mem_req=1, mem_we=1, mem_addr=0x0020, Stall=1 for exactly 3 cycles; completes on the 4th.
REQ-026 Load with mem_ready held 0 -> after TIMEOUT=15 wait cycles, Err=1, mem_req=0, Stall=0, WB_RegWrt=0.
REQ-027 Load at ALU_Out=0x0011 -> no mem_req, Err=1; and MemRead=MemWrt=1 -> no mem_req, Err=1.
REQ-028 Halt (nHaltSig=0, Valid=1), followed by a valid load -> Halt_wb=1 next edge; the later load produces no mem_req and WB_RegWrt=0.
REQ-029 rst=0 asserted mid-WAIT -> mem_req, Stall, Err and WB_RegWrt read 0 before the next clk edge.
